// File: rtl/rst_seq.sv
// Reset sequencer for clk_div: ordered release of the write/read divider resets
// after global reset, plus per-domain soft-reset pulses serviced from RUN.
module rst_seq #(
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int SOFT_CYCLES    = 8,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic w_soft_req,
  input  logic r_soft_req,
  output logic w_rst,
  output logic r_rst,
  output logic ready,
  output logic busy
);

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    STAG  = 3'd1,
    RUN   = 3'd2,
    WSOFT = 3'd3,
    RSOFT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_comb begin
    // NOTE: defaults first so every path assigns every variable; no latches.
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      HOLD: if (cnt == HOLD_LAST) begin
        state_nxt = STAG;
        cnt_nxt   = '0;
      end
      STAG: if (cnt == STAG_LAST) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
      RUN: begin
        cnt_nxt = '0;
        // Both requests together mean a full ordered restart, same as power-on.
        if (w_soft_req && r_soft_req)  state_nxt = HOLD;
        else if (w_soft_req)           state_nxt = WSOFT;
        else if (r_soft_req)           state_nxt = RSOFT;
      end
      WSOFT, RSOFT: if (cnt == SOFT_LAST) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered decodes of the next state, so they change on the
  // same edge as the state and never depend combinationally on the inputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state <= HOLD;
      cnt   <= '0;
      w_rst <= 1'b1;
      r_rst <= 1'b1;
      ready <= 1'b0;
      busy  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      w_rst <= (state_nxt == HOLD) || (state_nxt == WSOFT);
      r_rst <= (state_nxt == HOLD) || (state_nxt == STAG) || (state_nxt == RSOFT);
      ready <= (state_nxt == RUN);
      busy  <= (state_nxt != RUN);
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: directed per-cycle vector table, then
// random stimulus against a countdown-based reference model.
module tb_rst_seq;

  localparam int HOLD = 16;
  localparam int STAG = 4;
  localparam int SOFT = 8;

  logic clk = 1'b0;
  logic rst, w_soft_req, r_soft_req;
  logic w_rst, r_rst, ready, busy;

  int n_cmp = 0;
  int n_bad = 0;

  rst_seq #(.HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG), .SOFT_CYCLES(SOFT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .w_soft_req(w_soft_req), .r_soft_req(r_soft_req),
    .w_rst(w_rst), .r_rst(r_rst), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit rs, wq, rq;
    bit ew, er, erdy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %b, want %b", name, idx, act, exp);
    end
  endtask

  task automatic add(input string nm, input bit rs, input bit wq, input bit rq,
                     input bit ew, input bit er, input bit erdy, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.name = nm; v.rs = rs; v.wq = wq; v.rq = rq;
      v.ew = ew; v.er = er; v.erdy = erdy;
      vecs.push_back(v);
    end
  endtask

  // Drive one cycle's inputs, clock, then check outputs just after the edge.
  task automatic step_check(input string nm, input int idx, input bit rs, input bit wq,
                            input bit rq, input bit ew, input bit er, input bit erdy);
    rst = rs; w_soft_req = wq; r_soft_req = rq;
    @(posedge clk);
    #1;
    check({nm, ".w_rst"}, idx, w_rst, ew);
    check({nm, ".r_rst"}, idx, r_rst, er);
    check({nm, ".ready"}, idx, ready, erdy);
    check({nm, ".busy"},  idx, busy,  !erdy);
    check({nm, ".inv"},   idx, ready, !(w_rst | r_rst));
  endtask

  // Power-on style sequence after a reset/restart edge: HOLD-1 more cycles with
  // both resets, STAG cycles with only r_rst, then RUN.
  task automatic add_restart(input string nm, input bit wq_in_stag);
    add({nm, "_hold"}, 0, 0, 0, 1, 1, 0, HOLD - 1);
    add({nm, "_stag"}, 0, wq_in_stag, 0, 0, 1, 0, STAG);
    add({nm, "_run"},  0, 0, 0, 0, 0, 1, 2);
  endtask

  // Reference model: remaining reset-asserted cycles per domain.
  int w_left, r_left;

  task automatic model_edge(input bit rs, input bit wq, input bit rq);
    if (rs) begin
      w_left = HOLD; r_left = HOLD + STAG;
    end else if (w_left == 0 && r_left == 0) begin
      if (wq && rq) begin
        w_left = HOLD; r_left = HOLD + STAG;
      end else if (wq) w_left = SOFT;
      else if (rq)     r_left = SOFT;
    end else begin
      if (w_left > 0) w_left--;
      if (r_left > 0) r_left--;
    end
  endtask

  initial begin
    rst = 1'b1; w_soft_req = 1'b0; r_soft_req = 1'b0;

    // Power-on: 3 reset cycles, a write request during STAG must be ignored.
    add("por_rst", 1, 0, 0, 1, 1, 0, 3);
    add_restart("por", 1'b1);
    // Write soft reset: 1-cycle request, w_rst high 8 cycles.
    add("wsoft_req", 0, 1, 0, 1, 0, 0, 1);
    add("wsoft",     0, 0, 0, 1, 0, 0, SOFT - 1);
    add("wsoft_end", 0, 0, 0, 0, 0, 1, 2);
    // Read soft reset.
    add("rsoft_req", 0, 0, 1, 0, 1, 0, 1);
    add("rsoft",     0, 0, 0, 0, 1, 0, SOFT - 1);
    add("rsoft_end", 0, 0, 0, 0, 0, 1, 2);
    // Simultaneous requests: full ordered sequence.
    add("both_req", 0, 1, 1, 1, 1, 0, 1);
    add_restart("both", 1'b0);
    // rst mid-WSOFT aborts the pulse and restarts.
    add("mid_req",  0, 1, 0, 1, 0, 0, 1);
    add("mid_soft", 0, 0, 0, 1, 0, 0, 3);
    add("mid_rst",  1, 0, 0, 1, 1, 0, 1);
    add_restart("mid", 1'b0);
    // Held request for 20 cycles: back-to-back pulses with 1-cycle RUN gaps.
    for (int p = 0; p < 2; p++) begin
      add("held_pulse", 0, 1, 0, 1, 0, 0, SOFT);
      add("held_gap",   0, 1, 0, 0, 0, 1, 1);
    end
    add("held_pulse3", 0, 1, 0, 1, 0, 0, 2);
    add("held_tail",   0, 0, 0, 1, 0, 0, SOFT - 2);
    add("held_end",    0, 0, 0, 0, 0, 1, 2);

    foreach (vecs[i])
      step_check(vecs[i].name, i, vecs[i].rs, vecs[i].wq, vecs[i].rq,
                 vecs[i].ew, vecs[i].er, vecs[i].erdy);

    // Random phase against the countdown model, starting from a reset edge.
    model_edge(1'b1, 1'b0, 1'b0);
    step_check("rnd_sync", 0, 1, 0, 0, 1, 1, 0);
    for (int c = 1; c < 3000; c++) begin
      bit rs, wq, rq;
      rs = ($urandom_range(0, 99) == 0);
      wq = ($urandom_range(0, 9) == 0);
      rq = ($urandom_range(0, 9) == 0);
      model_edge(rs, wq, rq);
      step_check("rnd", c, rs, wq, rq, w_left > 0, r_left > 0,
                 (w_left == 0) && (r_left == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset sequencer directly upstream of clk_div, on the same 100 MHz clk.
- Generates the active-high domain resets w_rst (wclk divider, ÷2) and r_rst (rclk divider, ÷3) from the global reset.
- On release it holds both dividers in reset, frees the write divider first, then frees the read divider a fixed number of cycles later.
- Also services per-domain soft-reset requests and reports when both dividers are running.

Parameters:
- HOLD_CYCLES, 16: cycles both w_rst and r_rst stay asserted after rst deasserts; ≥1.
- STAGGER_CYCLES, 4: cycles between w_rst release and r_rst release; ≥1.
- SOFT_CYCLES, 8: width of a soft-reset pulse on a single domain; ≥1.
- CNT_W, 8: shared counter width; 2^CNT_W ≥ max(HOLD_CYCLES, STAGGER_CYCLES, SOFT_CYCLES).

Ports:
- clk  in  1  100 MHz system clock; also drives clk_div.
- rst  in  1  synchronous, active-high global reset.
- w_soft_req  in  1  request a soft reset of the write divider; level-sampled.
- r_soft_req  in  1  request a soft reset of the read divider; level-sampled.
- w_rst  out  1  active-high reset to clk_div w_rst.
- r_rst  out  1  active-high reset to clk_div r_rst.
- ready  out  1  1 when both dividers are out of reset and the FSM is in RUN.
- busy  out  1  1 in any state other than RUN.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port rst.
- All outputs are registered; no combinational path from inputs to outputs.
- rst=1 at a clk edge:
  - state=HOLD, cnt=0.
  - w_rst=1, r_rst=1, ready=0, busy=1.
  - Overrides everything, including a soft reset in progress: a soft pulse in flight is aborted and the full sequence restarts.
- States: HOLD, STAG, RUN, WSOFT, RSOFT. Encoding is free. The 2-bit encoding is not required.
- HOLD:
  - w_rst=1, r_rst=1. cnt increments each edge with rst=0.
  - When cnt==HOLD_CYCLES-1: go to STAG, cnt<=0, w_rst<=0.
  - w_rst therefore falls on the HOLD_CYCLES-th edge with rst=0.
- STAG:
  - w_rst=0, r_rst=1. cnt increments.
  - When cnt==STAGGER_CYCLES-1: go to RUN, cnt<=0, r_rst<=0, ready<=1, busy<=0.
  - r_rst falls exactly STAGGER_CYCLES edges after w_rst falls.
- RUN:
  - w_rst=0, r_rst=0, ready=1. Requests are sampled each edge.
  - w_soft_req=1 and r_soft_req=0: go to WSOFT, cnt<=0, w_rst<=1, ready<=0, busy<=1.
  - r_soft_req=1 and w_soft_req=0: go to RSOFT, cnt<=0, r_rst<=1, ready<=0, busy<=1.
  - Both requests 1 on the same edge: go to HOLD, cnt<=0, both resets 1. This is the full ordered sequence, identical to power-on.
- WSOFT:
  - w_rst=1, r_rst=0. cnt increments.
  - When cnt==SOFT_CYCLES-1: go to RUN, w_rst<=0, ready<=1, busy<=0.
  - w_rst is high for exactly SOFT_CYCLES cycles.
- RSOFT: same as WSOFT with r_rst in place of w_rst.
- Requests outside RUN are ignored, not queued.
- A request still held high when the FSM returns to RUN is re-sampled on the next edge and triggers a new soft reset. Requesters must drop the request once they see busy=1.
- cnt never wraps in normal operation; the terminal compares bound it.
- An unreachable or illegal state encoding recovers to HOLD on the next edge.
- Invariant: ready==!(w_rst|r_rst) and ready==!busy in every cycle.

Test Plan:
- Power-on, default parameters:
  - Stimulus: rst=1 for 3 cycles, then 0.
  - Response: w_rst falls on the 16th edge with rst=0. r_rst falls on the 20th. ready rises on the 20th edge. busy falls on the 20th edge.
- Write soft reset:
  - Stimulus: in RUN, w_soft_req=1 for 1 cycle.
  - Response: w_rst high for exactly 8 cycles, r_rst stays 0, ready low for 8 cycles, then ready=1.
- Read soft reset:
  - Stimulus: in RUN, r_soft_req=1 for 1 cycle.
  - Response: r_rst high 8 cycles, w_rst stays 0.
- Simultaneous requests:
  - Stimulus: w_soft_req=r_soft_req=1 on the same cycle.
  - Response: full sequence; w_rst released after 16 cycles, r_rst 4 cycles later.
- Ignored request and mid-sequence reset:
  - Stimulus: w_soft_req=1 during STAG.
  - Response: ignored; r_rst still falls at edge 20.
  - Stimulus: rst=1 asserted mid-WSOFT.
  - Response: next edge both resets =1, state=HOLD, and the sequence restarts with the 16/20 timing.
- Held request:
  - Stimulus: w_soft_req held high for 20 cycles.
  - Response: back-to-back WSOFT pulses with a single-cycle RUN gap (ready=1 for 1 cycle) between them.
- All scenarios: check the invariants ready==!(w_rst|r_rst) and ready==!busy every cycle.
